// File: rtl/harris_frame_sequencer.sv
// harris_frame_sequencer: streams one raster-order frame from pixel memory into the
// 3x3 window generator, issuing a new line only when a line buffer has been freed.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, cfg_base   frame start request (ignored while busy) and frame base address
//   busy, done, err   frame in progress, completion pulse, sticky spurious-return flag
//   mem_req/addr/gnt  read request channel
//   mem_rdata/rvalid  in-order read return channel
//   win_reset         reset pulse to the window generator
//   pixel/pixel_valid returned pixel, registered one cycle
//   window_valid      row-read strobe from the window generator
//   rows_done         window rows completed in the current frame
module harris_frame_sequencer #(
   parameter int IMG_WIDTH       = 512,
   parameter int IMG_HEIGHT      = 512,
   parameter int PIX_W           = 8,
   parameter int ADDR_W          = 18,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_base,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [PIX_W-1:0]  mem_rdata,
   input  logic              mem_rvalid,
   output logic              win_reset,
   output logic [PIX_W-1:0]  pixel,
   output logic              pixel_valid,
   input  logic              window_valid,
   output logic [15:0]       rows_done
);
   localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, INIT, FETCH, WAIT_CREDIT, DRAIN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [15:0]   lines_issued;
   logic [3:0]    outstanding;
   logic          wv_q;
   logic          accept;
   logic          start_acc;
   logic          row_fall;
   logic          last_col;
   logic [16:0]   credit_lim;
   logic [16:0]   lines_next;

   // Outputs are pure decodes of registered state, so they carry no input paths.
   assign busy       = state != IDLE;
   assign done       = state == DONE;
   assign win_reset  = state == INIT;
   assign mem_req    = (state == FETCH) && (outstanding < 4'(MAX_OUTSTANDING));
   assign accept     = mem_req & mem_gnt;
   assign start_acc  = start & (state == IDLE);
   assign row_fall   = wv_q & ~window_valid;
   assign last_col   = col == CW'(IMG_WIDTH - 1);
   // A line may be issued only while fewer than rows_done+4 lines are out,
   // which keeps the 4-line buffer ring from being overwritten mid-read.
   assign credit_lim = {1'b0, rows_done} + 17'd4;
   assign lines_next = {1'b0, lines_issued} + 17'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         mem_addr     <= '0;
         col          <= '0;
         lines_issued <= '0;
         outstanding  <= '0;
         err          <= 1'b0;
         pixel        <= '0;
         pixel_valid  <= 1'b0;
         wv_q         <= 1'b0;
         rows_done    <= '0;
      end else begin
         pixel       <= mem_rdata;
         pixel_valid <= mem_rvalid;
         wv_q        <= window_valid;
         err         <= start_acc ? 1'b0 : err | (mem_rvalid & (outstanding == 4'd0));
         if (accept && !mem_rvalid)
            outstanding <= outstanding + 4'd1;
         else if (!accept && mem_rvalid && outstanding != 4'd0)
            outstanding <= outstanding - 4'd1;
         rows_done <= start_acc ? 16'd0 : rows_done + 16'(row_fall);
         case (state)
            IDLE: if (start) begin
               mem_addr     <= cfg_base;
               col          <= '0;
               lines_issued <= '0;
               state        <= INIT;
            end
            INIT: state <= FETCH;
            FETCH: if (accept) begin
               mem_addr <= mem_addr + 1'b1;
               col      <= last_col ? '0 : col + 1'b1;
               if (last_col) begin
                  lines_issued <= lines_next[15:0];
                  if (lines_next == 17'(IMG_HEIGHT))
                     state <= DRAIN;
                  else if (lines_next >= credit_lim)
                     state <= WAIT_CREDIT;
               end
            end
            WAIT_CREDIT: if ({1'b0, lines_issued} < credit_lim) state <= FETCH;
            DRAIN: if (outstanding == 4'd0 && rows_done == 16'(IMG_HEIGHT - 2)) state <= DONE;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_harris_frame_sequencer.sv
// tb_harris_frame_sequencer: scoreboard bench with a memory model, a behavioural
// window generator and a pixel monitor for harris_frame_sequencer.
module tb_harris_frame_sequencer;
   localparam int W = 8, H = 6, AW = 18, PW = 8, MO = 4;

   logic clk = 0, reset = 1, start = 0, mem_gnt = 0, mem_rvalid = 0, window_valid = 0;
   logic [AW-1:0] cfg_base = '0;
   logic [PW-1:0] mem_rdata = '0;
   logic busy, done, err, mem_req, win_reset, pixel_valid;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] pixel;
   logic [15:0] rows_done;

   harris_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW), .ADDR_W(AW),
      .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .busy(busy),
      .done(done), .err(err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .win_reset(win_reset),
      .pixel(pixel), .pixel_valid(pixel_valid), .window_valid(window_valid),
      .rows_done(rows_done));

   always #5 clk = ~clk;

   typedef struct {int due; logic [PW-1:0] data;} ret_t;
   ret_t rq[$];
   ret_t r;
   logic [PW-1:0] exp_q[$];
   int tests = 0, fails = 0, cyc = 0, acc = 0, pv_cnt = 0, last_due = 0, due = 0;
   int lat_max = 1, row0_delay = 0, c31 = 0, c32 = 0, pv0 = 0;
   bit rst_req = 1, rand_gnt = 0, spur = 0, stalled = 0;
   logic [AW-1:0] exp_addr = '0, st_addr = '0;
   int wm_pix = 0, wm_rows = 0, wm_t = 0;
   bit wm_act = 0;

   function automatic logic [PW-1:0] img(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {6'h0, a[17:16]} ^ 8'h3C;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   // Memory: applies reset requests, returns data in order, accepts requests.
   initial forever begin
      @(negedge clk);
      cyc++;
      reset = rst_req;
      mem_rvalid = 0;
      if (spur) begin
         mem_rvalid = 1; mem_rdata = 8'hA5; exp_q.push_back(8'hA5); spur = 0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
         r = rq.pop_front();
         mem_rvalid = 1; mem_rdata = r.data;
         if (!reset) exp_q.push_back(r.data);
      end
      if (stalled && !reset) chk("addr_hold", {mem_req, mem_addr}, {1'b1, st_addr});
      mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = mem_req && !mem_gnt;
      st_addr = mem_addr;
      if (mem_req && mem_gnt) begin
         due = cyc + int'($urandom_range(1, lat_max));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         rq.push_back('{due, img(mem_addr)});
         if (!reset) begin
            chk("addr", mem_addr, exp_addr);
            chk("credit", 32'(acc / W < int'(rows_done) + 4), 1);
            chk("outstanding", 32'(rq.size() <= MO), 1);
            if (acc == 31) c31 = cyc;
            if (acc == 32) c32 = cyc;
            exp_addr++;
            acc++;
         end
      end
   end

   // Monitor: every presented pixel is checked against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (pixel_valid) begin
         pv_cnt++;
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL pixel_unexpected: got %0h want none", pixel);
         end else chk("pixel", pixel, exp_q.pop_front());
      end
   end

   // Window generator: row r completes once (r+3) lines of pixels have arrived.
   initial forever begin
      @(negedge clk);
      if (reset || win_reset) begin
         wm_pix = 0; wm_rows = 0; wm_act = 0; window_valid = 0;
      end else begin
         if (pixel_valid) wm_pix++;
         if (!wm_act && wm_rows < H - 2 && wm_pix >= (wm_rows + 3) * W) begin
            wm_act = 1; wm_t = (wm_rows == 0 ? row0_delay : 0) + 3;
         end
         if (wm_act) begin
            wm_t--;
            window_valid = (wm_t == 1 || wm_t == 2);
            if (wm_t == 0) begin wm_act = 0; wm_rows++; end
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 200 && rq.size() > 0; i++) @(negedge clk);
      chk("drain", rq.size(), 0);
   endtask

   task automatic run_frame(input logic [AW-1:0] b, input bit rg, input int lmax,
                            input int d0, input bit poke);
      drain();
      repeat (2) @(negedge clk);
      rand_gnt = rg; lat_max = lmax; row0_delay = d0;
      exp_addr = b; acc = 0; c31 = 0; c32 = 0; pv0 = pv_cnt;
      @(negedge clk); start = 1; cfg_base = b;
      @(negedge clk); start = 0;
      chk("busy_t1", busy, 1);
      chk("win_reset_t1", win_reset, 1);
      chk("err_cleared", err, 0);
      @(negedge clk);
      chk("req_t2", mem_req, 1);
      chk("addr_t2", mem_addr, b);
      if (poke) begin
         repeat (5) @(negedge clk);
         start = 1; cfg_base = 18'h777;
         @(negedge clk); start = 0;
         chk("busy_poke", busy, 1);
      end
      for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
      chk("done_seen", done, 1);
      chk("rows_done", rows_done, H - 2);
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("done_pulse", done, 0);
      chk("accepts", acc, W * H);
      chk("pixels", pv_cnt - pv0, W * H);
      chk("err_frame", err, 0);
      chk("sb_empty", exp_q.size(), 0);
      if (d0 > 0) chk("credit_stall", 32'(c32 - c31 > 50), 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_req = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_win_reset", win_reset, 0);
      chk("rst_pv", pixel_valid, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_pixel", pixel, 0);
      chk("rst_rows", rows_done, 0);

      pv0 = pv_cnt; spur = 1;
      repeat (3) @(negedge clk);
      chk("spur_err", err, 1);
      chk("spur_pv", pv_cnt - pv0, 1);

      run_frame(18'h100, 0, 1, 0, 0);
      run_frame(18'h140, 0, 1, 100, 0);
      run_frame(18'h2000, 1, 5, 0, 0);
      run_frame(18'h3FFFC, 0, 1, 0, 1);

      drain();
      rand_gnt = 0; lat_max = 3; row0_delay = 0; exp_addr = 18'h500; acc = 0;
      @(negedge clk); start = 1; cfg_base = 18'h500;
      @(negedge clk); start = 0;
      for (int i = 0; i < 200 && acc < 2 * W + 3; i++) @(negedge clk);
      chk("mid_line2", acc / W, 2);
      rst_req = 1;
      for (int i = 0; i < 5 && !reset; i++) @(negedge clk);
      rst_req = 0;
      for (int i = 0; i < 5 && reset; i++) @(negedge clk);
      chk("mid_busy", busy, 0);
      chk("mid_req", mem_req, 0);
      chk("mid_win_reset", win_reset, 0);
      chk("mid_done", done, 0);
      chk("mid_addr", mem_addr, 0);
      chk("mid_rows", rows_done, 0);
      drain();
      repeat (2) @(negedge clk);
      chk("mid_err", err, 1);
      run_frame(18'h600, 0, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
